// File: rtl/uart_rx_fifo_if.sv
// Host/receiver signal bundle for uart_rx_fifo.
// slave = the FIFO itself, master = whatever drives the receiver and host side.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
  parameter int CW = 5
);
  logic          RxDone;
  logic [7:0]    RxData;
  logic [3:0]    NBits;
  logic          RdReady;
  logic          OvfClr;
  logic          RdValid;
  logic [7:0]    RdData;
  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;
  logic          Overflow;

  modport slave (
    input  RxDone, RxData, NBits, RdReady, OvfClr,
    output RdValid, RdData, Count, Full, Empty, Overflow
  );

  modport master (
    output RxDone, RxData, NBits, RdReady, OvfClr,
    input  RdValid, RdData, Count, Full, Empty, Overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Edge-captured, right-aligned UART byte buffer with FWFT valid/ready read side.
// Define UART_RX_FIFO_OVERWRITE_EN to replace the oldest entry on overflow instead of dropping.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input logic           Clk,
  input logic           Rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rxdone_q;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          wr;
  logic          pop;
  logic          ovf_evt;
  logic          mem_we;
  logic          cnt_inc;

  function automatic logic [7:0] align_byte(input logic [7:0] d, input logic [3:0] nb);
    case (nb)
      4'd5:    return {3'b000, d[7:3]};
      4'd6:    return {2'b00, d[7:2]};
      4'd7:    return {1'b0, d[7:1]};
      default: return d;
    endcase
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr      = bus.RxDone & ~rxdone_q;
  assign pop     = ~empty & bus.RdReady;
  assign ovf_evt = wr & full & ~pop;
  assign cnt_inc = wr & ~ovf_evt;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  assign mem_we = wr;
`else
  assign mem_we = cnt_inc;
`endif

  // Storage carries no reset; only entries behind a valid count are ever read.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[wr_ptr] <= align_byte(bus.RxData, bus.NBits);
  end

  // rxdone_q resets high so a RxDone already asserted at release is not taken as an edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rxdone_q <= 1'b1;
      overflow <= 1'b0;
    end else begin
      rxdone_q <= bus.RxDone;
      if (mem_we) wr_ptr <= wr_ptr + AW'(1);
`ifdef UART_RX_FIFO_OVERWRITE_EN
      if (pop || ovf_evt) rd_ptr <= rd_ptr + AW'(1);
`else
      if (pop) rd_ptr <= rd_ptr + AW'(1);
`endif
      case ({cnt_inc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_evt)         overflow <= 1'b1;
      else if (bus.OvfClr) overflow <= 1'b0;
    end
  end

  assign bus.RdValid  = ~empty;
  assign bus.RdData   = empty ? 8'h00 : mem[rd_ptr];
  assign bus.Count    = count;
  assign bus.Full     = full;
  assign bus.Empty    = empty;
  assign bus.Overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16): capture, alignment, overflow, wrap, reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [7:0] q [$];
  logic [7:0] last_pop;

  uart_rx_fifo_if #(.CW(CW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference queue update for one clock edge with 8-bit frames.
  task automatic model_step(input logic w, input logic [7:0] d, input logic p);
    if (p && q.size() > 0) void'(q.pop_front());
    if (w) begin
      if (q.size() < DEPTH) q.push_back(d);
      else begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
        void'(q.pop_front());
        q.push_back(d);
`endif
      end
    end
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic rdy);
    bus.RxData  = d;
    bus.RxDone  = 1'b1;
    bus.RdReady = rdy;
    model_step(1'b1, d, rdy);
    tick();
    bus.RxDone  = 1'b0;
    bus.RdReady = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag);
    chk(tag, {31'd0, bus.RdValid}, 32'd1);
    chk(tag, {24'd0, bus.RdData}, {24'd0, q[0]});
    last_pop = bus.RdData;
    bus.RdReady = 1'b1;
    model_step(1'b0, 8'h00, 1'b1);
    tick();
    bus.RdReady = 1'b0;
  endtask

  task automatic raw_pop();
    bus.RdReady = 1'b1;
    tick();
    bus.RdReady = 1'b0;
  endtask

  logic [7:0] al_in  [4] = '{8'hA8, 8'hFC, 8'hFE, 8'hA8};
  logic [3:0] al_nb  [4] = '{4'd5,  4'd6,  4'd7,  4'd4};
  logic [7:0] al_exp [4] = '{8'h15, 8'h3F, 8'h7F, 8'hA8};

  initial begin
    bus.RxDone  = 1'b1;
    bus.RxData  = 8'h55;
    bus.NBits   = 4'd8;
    bus.RdReady = 1'b0;
    bus.OvfClr  = 1'b0;
    last_pop    = 8'h00;

    // T1: reset state, and RxDone held high through release is ignored
    tick(); tick();
    chk("rst_count", {27'd0, bus.Count}, 32'd0);
    chk("rst_full",  {31'd0, bus.Full}, 32'd0);
    chk("rst_ovf",   {31'd0, bus.Overflow}, 32'd0);
    Rst = 1'b0;
    tick(); tick(); tick();
    chk("t1_count", {27'd0, bus.Count}, 32'd0);
    chk("t1_empty", {31'd0, bus.Empty}, 32'd1);
    chk("t1_valid", {31'd0, bus.RdValid}, 32'd0);
    chk("t1_data",  {24'd0, bus.RdData}, 32'd0);
    bus.RxDone = 1'b0;
    tick();

    // T2: three bytes, FWFT head one cycle after first capture
    bus.RxData = 8'h41; bus.RxDone = 1'b1;
    model_step(1'b1, 8'h41, 1'b0);
    tick();
    chk("t2_valid1", {31'd0, bus.RdValid}, 32'd1);
    chk("t2_head1",  {24'd0, bus.RdData}, 32'h41);
    bus.RxDone = 1'b0;
    tick();
    rx_byte(8'h42, 1'b0);
    rx_byte(8'h43, 1'b0);
    chk("t2_count", {27'd0, bus.Count}, 32'd3);
    chk("t2_pop1", {24'd0, bus.RdData}, 32'h41); pop_chk("t2_m1");
    chk("t2_pop2", {24'd0, bus.RdData}, 32'h42); pop_chk("t2_m2");
    chk("t2_pop3", {24'd0, bus.RdData}, 32'h43); pop_chk("t2_m3");
    chk("t2_empty", {31'd0, bus.Empty}, 32'd1);
    chk("t2_data0", {24'd0, bus.RdData}, 32'd0);

    // T3: long RxDone gives one entry; alignment per frame width
    for (int i = 0; i < 4; i++) begin
      bus.NBits  = al_nb[i];
      bus.RxData = al_in[i];
      bus.RxDone = 1'b1;
      tick(); tick(); tick(); tick();
      bus.RxDone = 1'b0;
      tick();
      chk($sformatf("t3_count%0d", i), {27'd0, bus.Count}, 32'd1);
      chk($sformatf("t3_align%0d", i), {24'd0, bus.RdData}, {24'd0, al_exp[i]});
      raw_pop();
    end
    bus.NBits = 4'd8;
    chk("t3_empty", {31'd0, bus.Empty}, 32'd1);

    // T4: fill, overflow, clear, set-beats-clear
    for (int i = 0; i < DEPTH; i++) rx_byte(8'(i), 1'b0);
    chk("t4_full",  {31'd0, bus.Full}, 32'd1);
    chk("t4_ovf0",  {31'd0, bus.Overflow}, 32'd0);
    rx_byte(8'h10, 1'b0);
    chk("t4_ovf1",  {31'd0, bus.Overflow}, 32'd1);
    chk("t4_count", {27'd0, bus.Count}, 32'd16);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    chk("t4_head",  {24'd0, bus.RdData}, 32'h01);
`else
    chk("t4_head",  {24'd0, bus.RdData}, 32'h00);
`endif
    bus.OvfClr = 1'b1; tick(); bus.OvfClr = 1'b0;
    chk("t4_clr", {31'd0, bus.Overflow}, 32'd0);
    bus.RxData = 8'h11; bus.RxDone = 1'b1; bus.OvfClr = 1'b1;
    model_step(1'b1, 8'h11, 1'b0);
    tick();
    bus.OvfClr = 1'b0; bus.RxDone = 1'b0;
    chk("t4_setwins", {31'd0, bus.Overflow}, 32'd1);
    chk("t4_head2",   {24'd0, bus.RdData}, {24'd0, q[0]});
    tick();
    bus.OvfClr = 1'b1; tick(); bus.OvfClr = 1'b0;
    chk("t4_clr2", {31'd0, bus.Overflow}, 32'd0);

    // T5: full with same-cycle pop and write; drain; wrap pointers
    rx_byte(8'h20, 1'b1);
    chk("t5_count", {27'd0, bus.Count}, 32'd16);
    chk("t5_ovf",   {31'd0, bus.Overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("t5_drain%0d", i));
    chk("t5_last",  {24'd0, last_pop}, 32'h20);
    chk("t5_empty", {31'd0, bus.Empty}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      rx_byte(8'h80 + 8'(i), 1'b0);
      pop_chk($sformatf("t5_wrap%0d", i));
    end
    chk("t5_wrap_empty", {31'd0, bus.Empty}, 32'd1);

    // T6: async reset mid-stream
    for (int i = 0; i < 5; i++) rx_byte(8'hC0 + 8'(i), 1'b0);
    chk("t6_count5", {27'd0, bus.Count}, 32'd5);
    Rst = 1'b1;
    #1;
    chk("t6_count", {27'd0, bus.Count}, 32'd0);
    chk("t6_valid", {31'd0, bus.RdValid}, 32'd0);
    chk("t6_data",  {24'd0, bus.RdData}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    q.delete();
    tick();
    rx_byte(8'h5A, 1'b0);
    chk("t6_head",   {24'd0, bus.RdData}, 32'h5A);
    chk("t6_count1", {27'd0, bus.Count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
